ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 33 +++
 rtl/ram_arbiter_arb_rr2.sv | 28 ++
 rtl/ram_arbiter.sv | 135 +++++++++++++
 tb/tb_ram_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_pkg
// Description : Shared widths, FSM state encoding and port identifiers for
//               the two-port RAM arbiter and its round-robin picker.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arbiter_pkg;

  // Default RAM geometry, shared with the RAM model.
  localparam int c_ADDR_W_DEF = 10;
  localparam int c_DATA_W_DEF = 20;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Requester identity; bit position in the req/grant vectors matches value.
  typedef enum logic {
    PORT_F = 1'b0,
    PORT_D = 1'b1
  } port_t;

  // One-hot mask selecting a port's bit in a req/grant vector.
  function automatic logic [1:0] port_mask(input port_t p);
    return (p == PORT_D) ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_arb_rr2.sv
`default_nettype none
// ============================================================================
// Module      : arb_rr2
// Description : Combinational two-input round-robin picker. A lone requester
//               wins; on a tie the port that was not granted last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_rr2
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      last_grant,
  output logic [1:0] grant
);

  // Pick at most one winner from the two request lines.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == PORT_D) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Shares one single-port RAM between a read-only fetch port and
//               a load/store data port. IDLE -> BUSY (RAM command) -> DONE
//               (ack), with back-to-back DONE -> BUSY when the other port is
//               waiting. The RAM read path is combinational, so read data is
//               captured at the BUSY -> DONE edge and is valid with the ack.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W_DEF,
  parameter int DATA_W = c_DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_data,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  // RAM side
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_write,
  output logic              ram_str,
  output logic              ram_ld,
  input  logic [DATA_W-1:0] ram_read
);

  state_t            r_state;
  port_t             r_sel;
  port_t             r_last;

  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  logic              w_launch;
  port_t             w_sel;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_str;
  logic              w_ld;

  // Eligible requests; the port being acked in DONE still holds its req, so it is masked out.
  always_comb begin
    w_req = {d_req, f_req};
    if (r_state == ST_DONE) begin
      w_req = w_req & ~port_mask(r_sel);
    end
  end

  arb_rr2 u_arb (
    .req        (w_req),
    .last_grant (r_last),
    .grant      (w_grant)
  );

  // RAM command that a new grant would load into the output registers.
  always_comb begin
    w_launch = |w_grant;
    w_sel    = w_grant[1] ? PORT_D : PORT_F;
    w_addr   = f_addr;
    w_wdata  = '0;
    w_str    = 1'b0;
    w_ld     = 1'b1;
    if (w_sel == PORT_D) begin
      w_addr  = d_addr;
      w_wdata = d_we ? d_wdata : '0;
      w_str   = d_we;
      w_ld    = ~d_we;
    end
  end

  // Arbiter FSM with all RAM-side and ack/data outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_sel     <= PORT_F;
      r_last    <= PORT_D;
      ram_addr  <= '0;
      ram_write <= '0;
      ram_str   <= 1'b0;
      ram_ld    <= 1'b0;
      f_ack     <= 1'b0;
      d_ack     <= 1'b0;
      f_data    <= '0;
      d_rdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          f_ack   <= 1'b0;
          d_ack   <= 1'b0;
          ram_str <= 1'b0;
          ram_ld  <= 1'b0;
          if (w_launch) begin
            r_state   <= ST_BUSY;
            r_sel     <= w_sel;
            r_last    <= w_sel;
            ram_addr  <= w_addr;
            ram_write <= w_wdata;
            ram_str   <= w_str;
            ram_ld    <= w_ld;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          r_state <= ST_DONE;
          ram_str <= 1'b0;
          ram_ld  <= 1'b0;
          if (r_sel == PORT_F) begin
            f_ack  <= 1'b1;
            f_data <= ram_read;
          end else begin
            d_ack <= 1'b1;
            if (ram_ld) begin
              d_rdata <= ram_read;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Directed self-checking bench for ram_arbiter with a
//               combinational-read RAM model (unwritten word a holds 3*a+7).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  localparam int AW = 10;
  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic          f_ack;
  logic [DW-1:0] f_data;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_write;
  logic          ram_str;
  logic          ram_ld;
  logic [DW-1:0] ram_read;

  int n_checks = 0;
  int n_fail   = 0;

  bit            wr_flag [0:(1<<AW)-1];
  logic [DW-1:0] wr_data [0:(1<<AW)-1];

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_ack     (f_ack),
    .f_data    (f_data),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .ram_addr  (ram_addr),
    .ram_write (ram_write),
    .ram_str   (ram_str),
    .ram_ld    (ram_ld),
    .ram_read  (ram_read)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    logic [DW-1:0] base;
    base = DW'(a) * 3 + 7;
    return wr_flag[a] ? wr_data[a] : base;
  endfunction

  // RAM model: combinational read, synchronous write.
  always_comb ram_read = mem_rd(ram_addr);

  always @(posedge clk) begin
    if (ram_str) begin
      wr_flag[ram_addr] <= 1'b1;
      wr_data[ram_addr] <= ram_write;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every-cycle protocol invariants.
  always @(negedge clk) begin
    check("str_ld_exclusive", {31'd0, ram_str & ram_ld}, 32'd0);
    check("acks_exclusive",   {31'd0, f_ack & d_ack},    32'd0);
    check("f_ack_needs_req",  {31'd0, f_ack & ~f_req},   32'd0);
    check("d_ack_needs_req",  {31'd0, d_ack & ~d_req},   32'd0);
  end

  logic [DW-1:0] f_exp [0:3];
  logic [DW-1:0] d_exp [0:3];

  initial begin
    f_exp[0] = 20'd37; f_exp[1] = 20'd40; f_exp[2] = 20'd43; f_exp[3] = 20'd46;
    d_exp[0] = 20'd67; d_exp[1] = 20'd70; d_exp[2] = 20'd73; d_exp[3] = 20'd76;

    // ---------------- reset state ----------------
    step();
    step();
    check("rst_ram_str",   32'(ram_str),   32'd0);
    check("rst_ram_ld",    32'(ram_ld),    32'd0);
    check("rst_ram_addr",  32'(ram_addr),  32'd0);
    check("rst_ram_write", 32'(ram_write), 32'd0);
    check("rst_f_ack",     32'(f_ack),     32'd0);
    check("rst_d_ack",     32'(d_ack),     32'd0);
    check("rst_f_data",    32'(f_data),    32'd0);
    check("rst_d_rdata",   32'(d_rdata),   32'd0);
    rst = 1'b0;

    // ---------------- single store: addr 5 <- 101 ----------------
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'd5; d_wdata = 20'd101;
    step();
    check("st_busy_str",   32'(ram_str),   32'd1);
    check("st_busy_ld",    32'(ram_ld),    32'd0);
    check("st_busy_addr",  32'(ram_addr),  32'd5);
    check("st_busy_wdata", 32'(ram_write), 32'd101);
    check("st_busy_noack", 32'(d_ack),     32'd0);
    step();
    check("st_done_ack",   32'(d_ack),     32'd1);
    check("st_done_str",   32'(ram_str),   32'd0);
    check("st_done_fack",  32'(f_ack),     32'd0);
    check("st_mem5",       32'(mem_rd(10'd5)), 32'd101);
    step();
    check("st_ack_pulse",  32'(d_ack),     32'd0);

    // ---------------- single load: addr 5 ----------------
    d_we = 1'b0; d_wdata = '0;
    step();
    check("ld_busy_ld",    32'(ram_ld),    32'd1);
    check("ld_busy_str",   32'(ram_str),   32'd0);
    check("ld_busy_addr",  32'(ram_addr),  32'd5);
    step();
    check("ld_done_ack",   32'(d_ack),     32'd1);
    check("ld_done_data",  32'(d_rdata),   32'd101);
    step();
    d_req = 1'b0;
    check("ld_ack_pulse",  32'(d_ack),     32'd0);

    // ---------------- reset, then simultaneous fetch(1) / load(2) ----------------
    rst = 1'b1;
    step();
    check("rst2_d_rdata",  32'(d_rdata),   32'd0);
    rst = 1'b0;
    f_req = 1'b1; f_addr = 10'd1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'd2;
    step();
    check("tie_fetch_first_addr", 32'(ram_addr),  32'd1);
    check("tie_fetch_ld",         32'(ram_ld),    32'd1);
    check("tie_fetch_wdata",      32'(ram_write), 32'd0);
    step();
    check("tie_f_ack",    32'(f_ack),  32'd1);
    check("tie_f_data",   32'(f_data), 32'd10);
    check("tie_d_noack",  32'(d_ack),  32'd0);
    step();
    f_req = 1'b0;
    check("tie_f_ack_pulse",   32'(f_ack),    32'd0);
    check("tie_data_busy_ld",  32'(ram_ld),   32'd1);
    check("tie_data_busy_addr",32'(ram_addr), 32'd2);
    step();
    check("tie_d_ack",    32'(d_ack),   32'd1);
    check("tie_d_rdata",  32'(d_rdata), 32'd13);
    step();
    d_req = 1'b0;
    check("tie_d_ack_pulse", 32'(d_ack), 32'd0);

    // ---------------- continuous requests from both ports: 8 accesses ----------------
    f_req = 1'b1; f_addr = 10'd10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'd20;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k >= 1) begin
        if ((k - 1) % 2 == 0) begin
          if (k - 1 >= 6) f_req = 1'b0;
          else            f_addr = f_addr + 10'd1;
        end else begin
          d_addr = d_addr + 10'd1;
        end
      end
      check("rr_busy_addr", 32'(ram_addr), (k % 2 == 0) ? 32'(10 + k/2) : 32'(20 + k/2));
      check("rr_busy_ld",   32'(ram_ld),   32'd1);
      step();
      if (k % 2 == 0) begin
        check("rr_f_ack",  32'(f_ack),  32'd1);
        check("rr_d_idle", 32'(d_ack),  32'd0);
        check("rr_f_data", 32'(f_data), 32'(f_exp[k/2]));
      end else begin
        check("rr_d_ack",   32'(d_ack),   32'd1);
        check("rr_f_idle",  32'(f_ack),   32'd0);
        check("rr_d_rdata", 32'(d_rdata), 32'(d_exp[k/2]));
      end
    end
    step();
    d_req = 1'b0;
    check("rr_end_d_ack", 32'(d_ack),  32'd0);
    check("rr_end_ld",    32'(ram_ld), 32'd0);

    // ---------------- reset during BUSY of a store to addr 3 ----------------
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'd3; d_wdata = 20'd555;
    step();
    check("ab_busy_str",  32'(ram_str),  32'd1);
    check("ab_busy_addr", 32'(ram_addr), 32'd3);
    #2;
    rst = 1'b1;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    #1;
    check("ab_async_str",   32'(ram_str),   32'd0);
    check("ab_async_addr",  32'(ram_addr),  32'd0);
    check("ab_async_wdata", 32'(ram_write), 32'd0);
    step();
    check("ab_no_ack",   32'(d_ack),  32'd0);
    check("ab_mem3",     32'(mem_rd(10'd3)), 32'd16);
    check("ab_f_data",   32'(f_data), 32'd0);
    check("ab_d_rdata",  32'(d_rdata),32'd0);

    // ---------------- first grant on the first edge after reset release ----------------
    rst = 1'b0;
    f_req = 1'b1; f_addr = 10'd7;
    step();
    check("post_rst_ld",   32'(ram_ld),   32'd1);
    check("post_rst_addr", 32'(ram_addr), 32'd7);
    step();
    check("post_rst_f_ack",  32'(f_ack),  32'd1);
    check("post_rst_f_data", 32'(f_data), 32'd28);
    step();
    f_req = 1'b0;
    check("post_rst_ack_pulse", 32'(f_ack), 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
